// File: rtl/hex_to_seven_seg.sv
// Registered hex nibble to seven-segment decoder with load/blank.
// Define SEG_ACTIVE_LOW_EN for common-anode (inverted) segment drive.
module hex_to_seven_seg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hex,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] segments,
    output logic       valid
);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_INV = 7'b1111111;
`else
    localparam logic [6:0] SEG_INV = 7'b0000000;
`endif

    // All-dark pattern in the selected drive polarity
    localparam logic [6:0] SEG_OFF = SEG_INV;

    logic [6:0] w_decoded;
    logic [6:0] w_drive;
    logic [6:0] r_segments;
    logic       r_valid;

    // Active-high abcdefg pattern for every nibble value
    always_comb begin
        w_decoded = 7'b0000000;
        unique case (hex)
            4'h0: w_decoded = 7'b1111110;
            4'h1: w_decoded = 7'b0110000;
            4'h2: w_decoded = 7'b1101101;
            4'h3: w_decoded = 7'b1111001;
            4'h4: w_decoded = 7'b0110011;
            4'h5: w_decoded = 7'b1011011;
            4'h6: w_decoded = 7'b1011111;
            4'h7: w_decoded = 7'b1110000;
            4'h8: w_decoded = 7'b1111111;
            4'h9: w_decoded = 7'b1111011;
            4'hA: w_decoded = 7'b1110111;
            4'hB: w_decoded = 7'b0011111;
            4'hC: w_decoded = 7'b1001110;
            4'hD: w_decoded = 7'b0111101;
            4'hE: w_decoded = 7'b1001111;
            4'hF: w_decoded = 7'b1000111;
            default: w_decoded = 7'b0000000;
        endcase
    end

    assign w_drive = w_decoded ^ SEG_INV;

    // Display register: reset > blank > load > hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_segments <= SEG_OFF;
            r_valid    <= 1'b0;
        end else if (blank) begin
            r_segments <= SEG_OFF;
            r_valid    <= 1'b0;
        end else if (load) begin
            r_segments <= w_drive;
            r_valid    <= 1'b1;
        end
    end

    assign segments = r_segments;
    assign valid    = r_valid;

endmodule

// File: tb/tb_hex_to_seven_seg.sv
// Directed, table-driven bench for hex_to_seven_seg.
// Expectations follow SEG_ACTIVE_LOW_EN when it is defined.
module tb_hex_to_seven_seg;

    logic       clk;
    logic       rst_n;
    logic [3:0] hex;
    logic       load;
    logic       blank;
    logic [6:0] segments;
    logic       valid;

    int n_tests;
    int n_fail;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       load;
        logic       blank;
        logic [3:0] hex;
        logic [6:0] seg;
        logic       valid;
    } vec_t;

    vec_t vecs[$];
    logic [6:0] tbl [0:15];

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] INV = 7'b1111111;
`else
    localparam logic [6:0] INV = 7'b0000000;
`endif

    hex_to_seven_seg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hex      (hex),
        .load     (load),
        .blank    (blank),
        .segments (segments),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(
        input string      nm,
        input logic       r,
        input logic       l,
        input logic       b,
        input logic [3:0] h,
        input logic [6:0] s,
        input logic       v
    );
        vec_t t;
        t.name  = nm;
        t.rst_n = r;
        t.load  = l;
        t.blank = b;
        t.hex   = h;
        t.seg   = s ^ INV;
        t.valid = v;
        vecs.push_back(t);
    endfunction

    task automatic check(
        input string      nm,
        input logic [6:0] es,
        input logic       ev
    );
        n_tests++;
        if (segments !== es || valid !== ev) begin
            n_fail++;
            $display("FAIL %s: got seg=%b valid=%b, want seg=%b valid=%b",
                     nm, segments, valid, es, ev);
        end
    endtask

    task automatic step(input vec_t t);
        @(negedge clk);
        rst_n = t.rst_n;
        load  = t.load;
        blank = t.blank;
        hex   = t.hex;
        @(posedge clk);
        #1;
        check(t.name, t.seg, t.valid);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        blank   = 1'b0;
        hex     = 4'h0;

        tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        // Reset dominates load
        add("rst0", 1'b0, 1'b1, 1'b0, 4'h8, 7'b0, 1'b0);
        add("rst1", 1'b0, 1'b1, 1'b0, 4'h8, 7'b0, 1'b0);
        add("rel0", 1'b1, 1'b0, 1'b0, 4'h8, 7'b0, 1'b0);
        add("rel1", 1'b1, 1'b0, 1'b0, 4'h3, 7'b0, 1'b0);
        // Full sweep, back-to-back loads
        for (int i = 0; i < 16; i++)
            add($sformatf("sweep%0h", i), 1'b1, 1'b1, 1'b0,
                4'(i), tbl[i], 1'b1);
        // Hold ignores hex
        add("ld2",   1'b1, 1'b1, 1'b0, 4'h2, 7'b1101101, 1'b1);
        add("hold0", 1'b1, 1'b0, 1'b0, 4'h5, 7'b1101101, 1'b1);
        add("hold1", 1'b1, 1'b0, 1'b0, 4'h5, 7'b1101101, 1'b1);
        add("hold2", 1'b1, 1'b0, 1'b0, 4'hF, 7'b1101101, 1'b1);
        // Blank beats load
        add("ld9",   1'b1, 1'b1, 1'b0, 4'h9, 7'b1111011, 1'b1);
        add("blank", 1'b1, 1'b1, 1'b1, 4'h3, 7'b0, 1'b0);
        add("bhold", 1'b1, 1'b0, 1'b0, 4'h3, 7'b0, 1'b0);
        add("unbl",  1'b1, 1'b1, 1'b0, 4'h3, 7'b1111001, 1'b1);
        // Reset mid-stream
        add("ms4",   1'b1, 1'b1, 1'b0, 4'h4, 7'b0110011, 1'b1);
        add("ms5",   1'b1, 1'b1, 1'b0, 4'h5, 7'b1011011, 1'b1);
        add("msrst", 1'b0, 1'b1, 1'b0, 4'h6, 7'b0, 1'b0);
        add("msld1", 1'b1, 1'b1, 1'b0, 4'h1, 7'b0110000, 1'b1);
        // Reset beats blank
        add("rstbl", 1'b0, 1'b1, 1'b1, 4'h8, 7'b0, 1'b0);
        add("ldC",   1'b1, 1'b1, 1'b0, 4'hC, 7'b1001110, 1'b1);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i]);

        // Exact one-cycle latency: output lags hex by one edge
        @(negedge clk);
        rst_n = 1'b1;
        blank = 1'b0;
        load  = 1'b1;
        hex   = 4'h8;
        #1;
        check("lat_pre", 7'b1001110 ^ INV, 1'b1);
        @(posedge clk);
        #1;
        check("lat_post", 7'b1111111 ^ INV, 1'b1);
        @(negedge clk);
        hex = 4'h1;
        @(posedge clk);
        #1;
        check("b2b_1", 7'b0110000 ^ INV, 1'b1);
        @(negedge clk);
        hex = 4'h0;
        @(posedge clk);
        #1;
        check("b2b_0", 7'b1111110 ^ INV, 1'b1);
        @(negedge clk);
        blank = 1'b1;
        load  = 1'b0;
        @(posedge clk);
        #1;
        check("blank_end", 7'b0 ^ INV, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_to_seven_seg.md
Name: hex_to_seven_seg

Overview:
Registered hexadecimal-to-seven-segment decoder. Converts a 4-bit nibble (0-F) into a 7-bit segment pattern for a single common-cathode display digit. It sits between datapath/status logic and the display pin drivers. Output is registered once per clock; load and blanking controls are provided.

Parameters:
None. All widths are fixed: 4-bit input, 7-bit segment output.

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
hex  input  4  nibble to display, 0x0-0xF
load  input  1  1 = capture and decode hex this cycle; 0 = hold current display
blank  input  1  1 = force all segments off (has priority over load)
segments  output  7  segment drive, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; 1 = segment lit
valid  output  1  1 once a digit has been loaded since reset/blank and is currently displayed

Behaviour:
- Single clock, synchronous active-low reset. No asynchronous paths; segments and valid are driven only from registers.
- Reset (rst_n=0 at clk edge): segments=7'b0000000, valid=0. Reset dominates blank and load.
- Priority each edge: reset > blank > load > hold.
- blank=1: next segments=7'b0000000, valid=0, regardless of load/hex.
- load=1, blank=0: next segments=decode(hex), valid=1. Latency: exactly 1 clock from the sampled hex to the segments update.
- load=0, blank=0: segments and valid hold their previous values; hex changes are ignored.
- Decode table (hex -> abcdefg):
  0->1111110, 1->0110000, 2->1101101, 3->1111001, 4->0110011, 5->1011011, 6->1011111, 7->1110000, 8->1111111, 9->1111011, A->1110111, b->0011111, C->1001110, d->0111101, E->1001111, F->1000111.
- Fully specified for all 16 codes; no don't-cares. X/Z on hex is not a supported input.
- Back-to-back loads: each cycle with load=1 updates the output on the next edge; no throughput limit.
- Reset mid-operation clears the display on that edge; the next load after reset release decodes normally.

Optional Feature:
Macro SEG_ACTIVE_LOW_EN selects common-anode drive.
- Defined: the segments output is the bitwise inverse of the table above (1 = segment off). Reset and blank drive 7'b1111111. For example, 0 -> 0000001 and 8 -> 0000000. valid is unchanged.
- Not defined: active-high drive as specified in Behaviour (reset/blank = 7'b0000000).

Test Plan:
- Reset: rst_n=0 for 2 cycles with load=1, hex=8 -> segments=0000000, valid=0; release -> still 0000000 until the first load.
- Full sweep: load=1, hex=0..F one per cycle -> segments follow the table one cycle later (e.g. 0->1111110, 7->1110000, A->1110111, F->1000111), valid=1.
- Hold: load hex=2 (1101101), then load=0 and hex changes to 5 -> segments stay 1101101 for 3+ cycles.
- Blank priority: displaying 9 (1111011), assert blank=1 with load=1, hex=3 -> next edge segments=0000000, valid=0; deassert blank with load=1 -> 1111001.
- Reset mid-stream: during the sweep at hex=6, pull rst_n=0 for one edge -> segments=0000000, valid=0; the next load of hex=1 -> 0110000.
- SEG_ACTIVE_LOW_EN build: reset -> 1111111; load hex=0 -> 0000001; load hex=C -> 0110001; blank -> 1111111.
